// File: rtl/id_ex_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_reg_pkg
// Shared definitions for the ID/EX pipeline register and its neighbours
// (signal_mux, alu, forwarding_unit): datapath widths, the ALU no-op code,
// the EX-stage slot record, the per-edge action encoding and small helpers.
// Optional feature macro: ID_EX_PERF_COUNTER_EN (perf counter width/limit
// are defined here unconditionally so the helper is always available).
// -----------------------------------------------------------------------------
package id_ex_reg_pkg;

  localparam int ISA_WIDTH     = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int ALU_OP_WIDTH  = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = 4'd0;

  localparam int                    PERF_WIDTH = 32;
  localparam logic [PERF_WIDTH-1:0] PERF_MAX   = 32'hFFFF_FFFF;

  // What the EX register does on the coming clock edge, highest priority first.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_FLUSH   = 2'd1,
    ACT_STALL   = 2'd2,
    ACT_CAPTURE = 2'd3
  } edge_action_e;

  // Contents of one EX slot.
  typedef struct packed {
    logic                     no_op;
    logic [ISA_WIDTH-1:0]     operand_1;
    logic [ISA_WIDTH-1:0]     operand_2;
    logic [ISA_WIDTH-1:0]     store_data;
    logic [REG_IDX_WIDTH-1:0] reg_1_idx;
    logic [REG_IDX_WIDTH-1:0] reg_2_idx;
    logic [REG_IDX_WIDTH-1:0] reg_dest_idx;
    logic [ALU_OP_WIDTH-1:0]  alu_op;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
  } stage_t;

  // An empty EX slot: marked as a bubble with every field cleared.
  function automatic stage_t bubble_stage();
    stage_t s;
    s.no_op        = 1'b1;
    s.operand_1    = {ISA_WIDTH{1'b0}};
    s.operand_2    = {ISA_WIDTH{1'b0}};
    s.store_data   = {ISA_WIDTH{1'b0}};
    s.reg_1_idx    = {REG_IDX_WIDTH{1'b0}};
    s.reg_2_idx    = {REG_IDX_WIDTH{1'b0}};
    s.reg_dest_idx = {REG_IDX_WIDTH{1'b0}};
    s.alu_op       = ALU_OP_NOP;
    s.mem_read     = 1'b0;
    s.mem_write    = 1'b0;
    s.reg_write    = 1'b0;
    return s;
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    logic [PERF_WIDTH-1:0] r;
    if (v == PERF_MAX) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_reg_if
// Bundle between the ID stage and the ID/EX register, and from the register
// to the EX stage.
//   id_*           : instruction slot presented by the ID stage
//   ex_*           : registered slot seen by the EX stage
//   load_use_stall : combinational hold request back to IF/ID and PC
//   bubble_count / flush_count : only with ID_EX_PERF_COUNTER_EN
// Modports:
//   master : the pipeline environment (drives id_*, observes ex_* and stall)
//   slave  : the id_ex_reg block (consumes id_*, drives ex_* and stall)
// -----------------------------------------------------------------------------
interface id_ex_reg_if;
  import id_ex_reg_pkg::*;

  logic                     id_no_op;
  logic [ISA_WIDTH-1:0]     id_operand_1;
  logic [ISA_WIDTH-1:0]     id_operand_2;
  logic [ISA_WIDTH-1:0]     id_store_data;
  logic [REG_IDX_WIDTH-1:0] id_reg_1_idx;
  logic [REG_IDX_WIDTH-1:0] id_reg_2_idx;
  logic [REG_IDX_WIDTH-1:0] id_reg_dest_idx;
  logic [ALU_OP_WIDTH-1:0]  id_alu_op;
  logic                     id_mem_read;
  logic                     id_mem_write;
  logic                     id_reg_write;

  logic                     load_use_stall;
  logic                     ex_no_op;
  logic [ISA_WIDTH-1:0]     ex_operand_1;
  logic [ISA_WIDTH-1:0]     ex_operand_2;
  logic [ISA_WIDTH-1:0]     ex_store_data;
  logic [REG_IDX_WIDTH-1:0] ex_reg_1_idx;
  logic [REG_IDX_WIDTH-1:0] ex_reg_2_idx;
  logic [REG_IDX_WIDTH-1:0] ex_reg_dest_idx;
  logic [ALU_OP_WIDTH-1:0]  ex_alu_op;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     ex_reg_write;

`ifdef ID_EX_PERF_COUNTER_EN
  logic [PERF_WIDTH-1:0]    bubble_count;
  logic [PERF_WIDTH-1:0]    flush_count;

  modport master (
    output id_no_op, id_operand_1, id_operand_2, id_store_data,
           id_reg_1_idx, id_reg_2_idx, id_reg_dest_idx, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write,
    input  load_use_stall, ex_no_op, ex_operand_1, ex_operand_2, ex_store_data,
           ex_reg_1_idx, ex_reg_2_idx, ex_reg_dest_idx, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_reg_write, bubble_count, flush_count
  );

  modport slave (
    input  id_no_op, id_operand_1, id_operand_2, id_store_data,
           id_reg_1_idx, id_reg_2_idx, id_reg_dest_idx, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write,
    output load_use_stall, ex_no_op, ex_operand_1, ex_operand_2, ex_store_data,
           ex_reg_1_idx, ex_reg_2_idx, ex_reg_dest_idx, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_reg_write, bubble_count, flush_count
  );
`else
  modport master (
    output id_no_op, id_operand_1, id_operand_2, id_store_data,
           id_reg_1_idx, id_reg_2_idx, id_reg_dest_idx, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write,
    input  load_use_stall, ex_no_op, ex_operand_1, ex_operand_2, ex_store_data,
           ex_reg_1_idx, ex_reg_2_idx, ex_reg_dest_idx, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_reg_write
  );

  modport slave (
    input  id_no_op, id_operand_1, id_operand_2, id_store_data,
           id_reg_1_idx, id_reg_2_idx, id_reg_dest_idx, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write,
    output load_use_stall, ex_no_op, ex_operand_1, ex_operand_2, ex_store_data,
           ex_reg_1_idx, ex_reg_2_idx, ex_reg_dest_idx, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_reg_write
  );
`endif

endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Pure combinational load-use hazard compare between the instruction in ID
// and the load currently in EX. A pause or flush suppresses the request, as
// does a gap on either side; index 0 never matches.
// Ports:
//   debug_pause, flush        : higher-priority pipeline controls
//   id_no_op, id_reg_*_idx    : consumer in ID
//   ex_no_op, ex_mem_read,
//   ex_reg_dest_idx           : producer in EX
//   stall                     : hold IF/ID and PC this cycle
// -----------------------------------------------------------------------------
module load_use_detect
  import id_ex_reg_pkg::*;
(
  input  logic                     debug_pause,
  input  logic                     flush,
  input  logic                     id_no_op,
  input  logic [REG_IDX_WIDTH-1:0] id_reg_1_idx,
  input  logic [REG_IDX_WIDTH-1:0] id_reg_2_idx,
  input  logic                     ex_no_op,
  input  logic                     ex_mem_read,
  input  logic [REG_IDX_WIDTH-1:0] ex_reg_dest_idx,
  output logic                     stall
);

  logic dest_valid_s;
  logic src_match_s;

  assign dest_valid_s = (ex_reg_dest_idx != {REG_IDX_WIDTH{1'b0}});
  assign src_match_s  = (id_reg_1_idx == ex_reg_dest_idx) |
                        (id_reg_2_idx == ex_reg_dest_idx);

  assign stall = ~debug_pause & ~flush & ~id_no_op & ~ex_no_op &
                 ex_mem_read & dest_valid_s & src_match_s;

endmodule

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID -> EX pipeline register. Captures the muxed operands, indices and
// control bits each cycle, inserts a one-cycle bubble on a load-use hazard,
// loads a bubble on flush and freezes completely on debug_pause.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset (EX restarts as a bubble)
//   debug_pause : hold every register, counters included
//   flush       : replace the incoming instruction with a bubble
//   bus         : id_ex_reg_if.slave (id_* in, ex_* / load_use_stall out,
//                 bubble_count / flush_count with ID_EX_PERF_COUNTER_EN)
// Optional feature macro: ID_EX_PERF_COUNTER_EN adds saturating counters of
// load-use bubbles and of flushes that discarded a real instruction.
// -----------------------------------------------------------------------------
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  input logic         debug_pause,
  input logic         flush,
  id_ex_reg_if.slave  bus
);

  stage_t       ex_r;
  stage_t       ex_next_s;
  stage_t       incoming_s;
  edge_action_e action_s;
  logic         stall_s;

  load_use_detect u_load_use_detect (
    .debug_pause     (debug_pause),
    .flush           (flush),
    .id_no_op        (bus.id_no_op),
    .id_reg_1_idx    (bus.id_reg_1_idx),
    .id_reg_2_idx    (bus.id_reg_2_idx),
    .ex_no_op        (ex_r.no_op),
    .ex_mem_read     (ex_r.mem_read),
    .ex_reg_dest_idx (ex_r.reg_dest_idx),
    .stall           (stall_s)
  );

  // Select this edge's action; pause beats flush beats the hazard bubble.
  always_comb begin
    action_s = ACT_CAPTURE;
    if (debug_pause) begin
      action_s = ACT_HOLD;
    end else if (flush) begin
      action_s = ACT_FLUSH;
    end else if (stall_s) begin
      action_s = ACT_STALL;
    end else begin
      action_s = ACT_CAPTURE;
    end
  end

  // Assemble the ID slot; a gap keeps its operands but drops all control and
  // indices so nothing downstream (forwarding, writeback) can act on it.
  always_comb begin
    incoming_s.no_op        = bus.id_no_op;
    incoming_s.operand_1    = bus.id_operand_1;
    incoming_s.operand_2    = bus.id_operand_2;
    incoming_s.store_data   = bus.id_store_data;
    incoming_s.reg_1_idx    = bus.id_reg_1_idx;
    incoming_s.reg_2_idx    = bus.id_reg_2_idx;
    incoming_s.reg_dest_idx = bus.id_reg_dest_idx;
    incoming_s.alu_op       = bus.id_alu_op;
    incoming_s.mem_read     = bus.id_mem_read;
    incoming_s.mem_write    = bus.id_mem_write;
    incoming_s.reg_write    = bus.id_reg_write;
    if (bus.id_no_op) begin
      incoming_s.reg_1_idx    = {REG_IDX_WIDTH{1'b0}};
      incoming_s.reg_2_idx    = {REG_IDX_WIDTH{1'b0}};
      incoming_s.reg_dest_idx = {REG_IDX_WIDTH{1'b0}};
      incoming_s.alu_op       = ALU_OP_NOP;
      incoming_s.mem_read     = 1'b0;
      incoming_s.mem_write    = 1'b0;
      incoming_s.reg_write    = 1'b0;
    end else begin
      incoming_s.no_op        = 1'b0;
    end
  end

  // Next EX slot content for the selected action.
  always_comb begin
    ex_next_s = ex_r;
    case (action_s)
      ACT_HOLD:             ex_next_s = ex_r;
      ACT_FLUSH, ACT_STALL: ex_next_s = bubble_stage();
      ACT_CAPTURE:          ex_next_s = incoming_s;
      default:              ex_next_s = bubble_stage();
    endcase
  end

  // EX slot register; reset leaves an empty pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r <= bubble_stage();
    end else begin
      ex_r <= ex_next_s;
    end
  end

  assign bus.load_use_stall  = stall_s;
  assign bus.ex_no_op        = ex_r.no_op;
  assign bus.ex_operand_1    = ex_r.operand_1;
  assign bus.ex_operand_2    = ex_r.operand_2;
  assign bus.ex_store_data   = ex_r.store_data;
  assign bus.ex_reg_1_idx    = ex_r.reg_1_idx;
  assign bus.ex_reg_2_idx    = ex_r.reg_2_idx;
  assign bus.ex_reg_dest_idx = ex_r.reg_dest_idx;
  assign bus.ex_alu_op       = ex_r.alu_op;
  assign bus.ex_mem_read     = ex_r.mem_read;
  assign bus.ex_mem_write    = ex_r.mem_write;
  assign bus.ex_reg_write    = ex_r.reg_write;

`ifdef ID_EX_PERF_COUNTER_EN
  logic [PERF_WIDTH-1:0] bubble_count_r;
  logic [PERF_WIDTH-1:0] flush_count_r;

  // Saturating event counters; they only move on edges that are not paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count_r <= {PERF_WIDTH{1'b0}};
      flush_count_r  <= {PERF_WIDTH{1'b0}};
    end else begin
      case (action_s)
        ACT_STALL: begin
          bubble_count_r <= sat_inc(bubble_count_r);
        end
        ACT_FLUSH: begin
          // Flushing a gap discards nothing, so it is not counted.
          if (!bus.id_no_op) begin
            flush_count_r <= sat_inc(flush_count_r);
          end else begin
            flush_count_r <= flush_count_r;
          end
        end
        default: begin
          bubble_count_r <= bubble_count_r;
          flush_count_r  <= flush_count_r;
        end
      endcase
    end
  end

  assign bus.bubble_count = bubble_count_r;
  assign bus.flush_count  = flush_count_r;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
// Self-checking bench for id_ex_reg. A behavioural model of the EX slot is
// advanced from the behaviour rules and compared with the DUT on every
// falling clock edge; directed steps add literal expectations.
// Honours ID_EX_PERF_COUNTER_EN when defined.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic debug_pause;
  logic flush;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .debug_pause (debug_pause),
    .flush       (flush),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the EX slot ----------------
  logic        m_no_op;
  logic [31:0] m_op1, m_op2, m_sd;
  logic [4:0]  m_r1, m_r2, m_rd;
  logic [3:0]  m_alu;
  logic        m_mr, m_mw, m_rw;
  logic [31:0] m_bub, m_fl;

  function automatic logic model_hazard();
    logic uses;
    uses = (bus.id_reg_1_idx == m_rd) || (bus.id_reg_2_idx == m_rd);
    return !debug_pause && !flush && !bus.id_no_op && !m_no_op && m_mr && (m_rd != 5'd0) && uses;
  endfunction

  task automatic m_empty();
    m_no_op <= 1'b1; m_op1 <= 32'd0; m_op2 <= 32'd0; m_sd <= 32'd0;
    m_r1 <= 5'd0; m_r2 <= 5'd0; m_rd <= 5'd0; m_alu <= 4'd0;
    m_mr <= 1'b0; m_mw <= 1'b0; m_rw <= 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_empty();
      m_bub <= 32'd0;
      m_fl  <= 32'd0;
    end else if (debug_pause) begin
      // frozen
    end else if (flush) begin
      m_empty();
      if (!bus.id_no_op) m_fl <= (m_fl == 32'hFFFF_FFFF) ? m_fl : m_fl + 32'd1;
    end else if (model_hazard()) begin
      m_empty();
      m_bub <= (m_bub == 32'hFFFF_FFFF) ? m_bub : m_bub + 32'd1;
    end else if (bus.id_no_op) begin
      // a gap keeps its data but carries no control
      m_empty();
      m_op1 <= bus.id_operand_1; m_op2 <= bus.id_operand_2; m_sd <= bus.id_store_data;
    end else begin
      m_no_op <= 1'b0;
      m_op1 <= bus.id_operand_1; m_op2 <= bus.id_operand_2; m_sd <= bus.id_store_data;
      m_r1 <= bus.id_reg_1_idx; m_r2 <= bus.id_reg_2_idx; m_rd <= bus.id_reg_dest_idx;
      m_alu <= bus.id_alu_op; m_mr <= bus.id_mem_read; m_mw <= bus.id_mem_write;
      m_rw <= bus.id_reg_write;
    end
  end

  // Compare every DUT output with the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("m_no_op", {31'd0, bus.ex_no_op}, {31'd0, m_no_op});
      check("m_operand_1", bus.ex_operand_1, m_op1);
      check("m_operand_2", bus.ex_operand_2, m_op2);
      check("m_store_data", bus.ex_store_data, m_sd);
      check("m_reg_1_idx", {27'd0, bus.ex_reg_1_idx}, {27'd0, m_r1});
      check("m_reg_2_idx", {27'd0, bus.ex_reg_2_idx}, {27'd0, m_r2});
      check("m_reg_dest_idx", {27'd0, bus.ex_reg_dest_idx}, {27'd0, m_rd});
      check("m_alu_op", {28'd0, bus.ex_alu_op}, {28'd0, m_alu});
      check("m_ctrl", {29'd0, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write},
            {29'd0, m_mr, m_mw, m_rw});
      check("m_stall", {31'd0, bus.load_use_stall}, {31'd0, model_hazard()});
`ifdef ID_EX_PERF_COUNTER_EN
      check("m_bubble_count", bus.bubble_count, m_bub);
      check("m_flush_count", bus.flush_count, m_fl);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic no_op, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [31:0] sd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [3:0] alu,
                       input logic mr, input logic mw, input logic rw);
    bus.id_no_op = no_op; bus.id_operand_1 = op1; bus.id_operand_2 = op2;
    bus.id_store_data = sd; bus.id_reg_1_idx = r1; bus.id_reg_2_idx = r2;
    bus.id_reg_dest_idx = rd; bus.id_alu_op = alu; bus.id_mem_read = mr;
    bus.id_mem_write = mw; bus.id_reg_write = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    debug_pause = 1'b0;
    flush       = 1'b0;
    drive(1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset values, before any clock edge
    check("rst_no_op", {31'd0, bus.ex_no_op}, 32'd1);
    check("rst_operand_1", bus.ex_operand_1, 32'd0);
    check("rst_ctrl", {29'd0, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write}, 32'd0);
`ifdef ID_EX_PERF_COUNTER_EN
    check("rst_bubble_count", bus.bubble_count, 32'd0);
`endif
    cmp_on = 1'b1;
    tick();
    rst_n = 1'b1;

    // Pass-through
    drive(1'b0, 32'h1234, 32'h55, 32'h66, 5'd1, 5'd2, 5'd5, 4'd3, 1'b0, 1'b0, 1'b1);
    tick();
    check("pass_operand_1", bus.ex_operand_1, 32'h1234);
    check("pass_dest", {27'd0, bus.ex_reg_dest_idx}, 32'd5);
    check("pass_reg_write", {31'd0, bus.ex_reg_write}, 32'd1);
    check("pass_no_op", {31'd0, bus.ex_no_op}, 32'd0);

    // Load-use: load to $8, then a consumer of $8
    drive(1'b0, 32'h100, 32'h4, 32'h0, 5'd2, 5'd0, 5'd8, 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h77, 32'h88, 32'h99, 5'd3, 5'd8, 5'd9, 4'd2, 1'b0, 1'b0, 1'b1);
    #1;
    check("lu_stall", {31'd0, bus.load_use_stall}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, bus.ex_no_op}, 32'd1);
    check("lu_bubble_mr", {31'd0, bus.ex_mem_read}, 32'd0);
    check("lu_stall_drop", {31'd0, bus.load_use_stall}, 32'd0);
    tick();
    check("lu_capture_r2", {27'd0, bus.ex_reg_2_idx}, 32'd8);
    check("lu_capture_rd", {27'd0, bus.ex_reg_dest_idx}, 32'd9);
    check("lu_capture_no_op", {31'd0, bus.ex_no_op}, 32'd0);
`ifdef ID_EX_PERF_COUNTER_EN
    check("lu_bubble_count", bus.bubble_count, 32'd1);
`endif

    // Zero index: load to $0 never stalls a reader of $0
    drive(1'b0, 32'h200, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h300, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 4'd2, 1'b0, 1'b0, 1'b1);
    #1;
    check("zero_stall", {31'd0, bus.load_use_stall}, 32'd0);
    tick();
    check("zero_no_bubble", bus.ex_operand_1, 32'h300);

    // Flush while a hazard holds
    drive(1'b0, 32'h400, 32'h0, 32'h0, 5'd1, 5'd0, 5'd7, 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h500, 32'h0, 32'h0, 5'd7, 5'd0, 5'd6, 4'd2, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, bus.load_use_stall}, 32'd0);
    tick();
    flush = 1'b0;
    check("flush_bubble", {31'd0, bus.ex_no_op}, 32'd1);
`ifdef ID_EX_PERF_COUNTER_EN
    check("flush_count", bus.flush_count, 32'd1);
    check("flush_bubble_count", bus.bubble_count, 32'd1);
`endif

    // Captured gap: data kept, control and indices dropped
    drive(1'b1, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4, 5'd4, 4'd0, 1'b1, 1'b1, 1'b1);
    tick();
    check("gap_ctrl", {29'd0, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write}, 32'd0);
    check("gap_dest", {27'd0, bus.ex_reg_dest_idx}, 32'd0);

    // Debug pause with a pending hazard and changing inputs
    drive(1'b0, 32'hAAAA, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    debug_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hC000 + i, 32'h0, 32'h0, 5'd3, 5'd3, 5'd10, 4'd6, 1'b0, 1'b0, 1'b1);
      flush = (i == 1);
      #1;
      check("pause_stall", {31'd0, bus.load_use_stall}, 32'd0);
      tick();
      check("pause_operand_1", bus.ex_operand_1, 32'hAAAA);
      check("pause_dest", {27'd0, bus.ex_reg_dest_idx}, 32'd3);
`ifdef ID_EX_PERF_COUNTER_EN
      check("pause_flush_count", bus.flush_count, 32'd1);
`endif
    end
    flush = 1'b0;
    drive(1'b0, 32'hBBBB, 32'h0, 32'h0, 5'd1, 5'd1, 5'd11, 4'd7, 1'b0, 1'b0, 1'b1);
    debug_pause = 1'b0;
    tick();
    check("resume_operand_1", bus.ex_operand_1, 32'hBBBB);

    // Reset asserted mid-stall
    drive(1'b0, 32'hD00, 32'h0, 32'h0, 5'd1, 5'd0, 5'd6, 4'd1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'hE00, 32'h0, 32'h0, 5'd6, 5'd0, 5'd12, 4'd2, 1'b0, 1'b0, 1'b1);
    #1;
    check("mid_stall", {31'd0, bus.load_use_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, bus.load_use_stall}, 32'd0);
    check("mid_rst_no_op", {31'd0, bus.ex_no_op}, 32'd1);
    check("mid_rst_dest", {27'd0, bus.ex_reg_dest_idx}, 32'd0);
`ifdef ID_EX_PERF_COUNTER_EN
    check("mid_rst_bubble_count", bus.bubble_count, 32'd0);
`endif
    #4 rst_n = 1'b1;
    tick();
    check("restart_capture", bus.ex_operand_1, 32'hE00);

    // Deterministic mixed sweep, checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      drive((i % 7) == 5, 32'h01010101 * i, 32'h10203 + i, 32'hF0F0 ^ i,
            5'(i % 4), 5'((i * 3) % 4), 5'((i * 5 + 1) % 4), 4'(i % 16),
            (i % 3) == 0, (i % 5) == 2, (i % 2) == 1);
      flush       = (i % 11) == 4;
      debug_pause = (i % 13) == 6;
      tick();
    end
    flush       = 1'b0;
    debug_pause = 1'b0;
    tick();
    cmp_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
Pipeline register between the ID stage (operand/index multiplexers) and the EX stage (ALU, forwarding unit).
- Captures the muxed operands, register indices and control bits each cycle.
- Detects load-use hazards against the instruction currently in EX and inserts a one-cycle bubble.
- Supports a debug pause (full freeze) and a flush to bubble.

Parameters:
ISA_WIDTH, 32, datapath and operand width
REG_IDX_WIDTH, 5, register-file index width
ALU_OP_WIDTH, 4, ALU opcode width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
debug_pause  input  1  debug-core halt; freezes all state
flush  input  1  replace the incoming instruction with a bubble
id_no_op  input  1  incoming ID slot is a gap
id_operand_1  input  ISA_WIDTH  ALU operand 1 from ID mux
id_operand_2  input  ISA_WIDTH  ALU operand 2 from ID mux
id_store_data  input  ISA_WIDTH  raw second-register value, for stores
id_reg_1_idx  input  REG_IDX_WIDTH  source index 1 (0 = unused)
id_reg_2_idx  input  REG_IDX_WIDTH  source index 2 (0 = unused)
id_reg_dest_idx  input  REG_IDX_WIDTH  destination index (0 = none)
id_alu_op  input  ALU_OP_WIDTH  ALU opcode
id_mem_read  input  1  load instruction
id_mem_write  input  1  store instruction
id_reg_write  input  1  writes register file
load_use_stall  output  1  combinational; IF/ID and PC must hold this cycle
ex_no_op  output  1  EX slot is a bubble
ex_operand_1, ex_operand_2, ex_store_data  output  ISA_WIDTH each  registered copies
ex_reg_1_idx, ex_reg_2_idx, ex_reg_dest_idx  output  REG_IDX_WIDTH each  registered copies
ex_alu_op  output  ALU_OP_WIDTH  registered copy
ex_mem_read, ex_mem_write, ex_reg_write  output  1 each  registered copies

Behaviour:
- Reset (rst_n=0, asynchronous): ex_no_op=1; every other registered output is 0; perf counters are 0.
- Latency: one cycle, ID to EX.
- Hazard signal (combinational): load_use_stall = ~debug_pause & ~flush & ~id_no_op & ~ex_no_op & ex_mem_read & (ex_reg_dest_idx != 0) & ((id_reg_1_idx == ex_reg_dest_idx) | (id_reg_2_idx == ex_reg_dest_idx)).
- Per-edge priority, highest first:
  1. debug_pause: hold all registers, including counters.
  2. flush: load a bubble.
  3. load_use_stall: load a bubble. ID holds its instruction, which is captured on the next cycle.
  4. Otherwise: capture all id_* inputs. ex_no_op = id_no_op.
- Bubble definition: ex_no_op=1; ex_mem_read, ex_mem_write, ex_reg_write = 0; all indices = 0; ex_alu_op = 0; operands and store data = 0.
- Captured gap (id_no_op=1 in the normal path): control bits and indices are forced to 0, exactly as for a bubble.
- Stall length: one cycle per load. After the bubble, ex_mem_read=0, so the stall cannot repeat for the same load.
- Simultaneous flush and hazard: flush wins; load_use_stall is low.
- Index 0 never matches. $zero writes never stall.
- Reset asserted mid-stall: the bubble and stall drop immediately; the pipeline restarts empty.

Optional Feature:
- Macro: ID_EX_PERF_COUNTER_EN.
- When defined, adds two outputs:
  - bubble_count, 32 bits: increments on each load-use bubble.
  - flush_count, 32 bits: increments on each flush that replaces a non-gap instruction.
- Both counters saturate at 32'hFFFF_FFFF, hold during debug_pause, and clear on reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared definitions header: ISA_WIDTH, REG_IDX_WIDTH, ALU_OP_WIDTH, and ALU_OP_NOP (0). All four are shared with signal_mux, alu and forwarding_unit.
- One sub-module: load_use_detect, the pure combinational hazard compare. It is reused later by the hazard/debug logic.
- Pipeline flops stay in the top module.

Test Plan:
1. Reset: rst_n=0 mid-cycle → all outputs 0, ex_no_op=1 immediately, with no clock edge.
2. Pass-through: id_operand_1=32'h1234, id_reg_dest_idx=5, id_reg_write=1 → one edge later ex_operand_1=32'h1234, ex_reg_dest_idx=5, ex_reg_write=1, ex_no_op=0.
3. Load-use: EX holds a load to $8; ID has id_reg_2_idx=8 → load_use_stall=1 that cycle; next edge EX is a bubble; following edge the ID instruction is captured; load_use_stall=0.
4. Zero index: EX holds a load to $0; ID reads $0 → load_use_stall=0, no bubble.
5. Flush plus hazard: flush=1 while a hazard condition holds → load_use_stall=0, EX gets a bubble; with ID_EX_PERF_COUNTER_EN, flush_count +1 and bubble_count unchanged.
6. Debug pause: debug_pause=1 for 3 cycles with changing ID inputs → all outputs and counters unchanged; on release, capture resumes on the next edge.
